// File: rtl/mic_pdm_capture_if.sv
// Signal bundle between the PDM capture block and its surroundings:
// microphone pins on one side, PCM sample strobe toward the PWM stage on the other.
interface mic_pdm_capture_if #(
    parameter int W = 8
);
    logic         enable;
    logic         mic_data;
    logic         mclk;
    logic         mic_lrsel;
    logic [W-1:0] pcm_out;
    logic         done;
    logic         active;
    logic [1:0]   state;

    // done is a one-cycle strobe with no back-pressure: the consumer must take
    // pcm_out on the cycle done is high; pcm_out then holds until the next strobe.
    modport master (
        input  enable, mic_data,
        output mclk, mic_lrsel, pcm_out, done, active, state
    );

    modport slave (
        output enable, mic_data,
        input  mclk, mic_lrsel, pcm_out, done, active, state
    );
endinterface

// File: rtl/mic_pdm_capture.sv
// PDM microphone capture: generates mclk, samples the bit stream on mclk falling
// edges and reports the ones count of each DECIM-bit window as a PCM sample.
module mic_pdm_capture #(
    parameter int CLK_DIV = 25,
    parameter int DECIM   = 64,
    parameter int W       = 8,
    parameter int WARMUP  = 2
) (
    input  logic               clk_in,
    input  logic               rst,
    mic_pdm_capture_if.master  bus
);
    localparam int DW      = $clog2(CLK_DIV);
    localparam int BW      = $clog2(DECIM);
    localparam int AW      = $clog2(DECIM + 1);
    localparam int WUW     = $clog2(WARMUP + 2);
    localparam int SW      = ((AW > W) ? AW : W) + 1;
    localparam int MAXV    = (1 << W) - 1;
    localparam int WU_LAST = (WARMUP > 0) ? WARMUP - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic           sync1;
    logic           d_s;
    logic [DW-1:0]  div;
    logic           mclk_r;
    logic [BW-1:0]  bit_cnt;
    logic [AW-1:0]  acc;
    logic [WUW-1:0] wu_cnt;
    logic [W-1:0]   pcm_r;
    logic           done_r;

    logic           counting;
    logic           div_wrap;
    logic           sample_ev;
    logic           win_end;
    logic           wu_last;
    logic [SW-1:0]  sum;
    logic [W-1:0]   pcm_sat;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            d_s   <= 1'b0;
        end else begin
            sync1 <= bus.mic_data;
            d_s   <= sync1;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (bus.enable) state_nx = (WARMUP == 0) ? S_RUN : S_WARMUP;
            end
            S_WARMUP: begin
                if (!bus.enable)           state_nx = S_IDLE;
                else if (win_end && wu_last) state_nx = S_RUN;
            end
            S_RUN: begin
                if (!bus.enable) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        counting      = (state != S_IDLE);
        bus.active    = (state == S_RUN);
        bus.state     = state;
        bus.mclk      = mclk_r;
        bus.mic_lrsel = 1'b0;
        bus.pcm_out   = pcm_r;
        bus.done      = done_r;
    end

    // A sample event is the divider wrap that takes mclk from 1 to 0.
    always_comb begin
        div_wrap  = counting && (div == DW'(CLK_DIV - 1));
        sample_ev = div_wrap && mclk_r;
        win_end   = sample_ev && (bit_cnt == BW'(DECIM - 1));
        wu_last   = (wu_cnt == WUW'(WU_LAST));
        sum       = SW'(acc) + SW'(d_s);
        pcm_sat   = (sum > SW'(MAXV)) ? {W{1'b1}} : sum[W-1:0];
    end

    // The window-end update is evaluated before the enable-drop clear, so a
    // window finishing on the same edge as enable falls still gets reported.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            div     <= '0;
            mclk_r  <= 1'b0;
            bit_cnt <= '0;
            acc     <= '0;
            wu_cnt  <= '0;
            pcm_r   <= '0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if ((state == S_RUN) && win_end) begin
                pcm_r  <= pcm_sat;
                done_r <= 1'b1;
            end
            if (!counting || !bus.enable) begin
                div     <= '0;
                mclk_r  <= 1'b0;
                bit_cnt <= '0;
                acc     <= '0;
                wu_cnt  <= '0;
            end else begin
                if (div_wrap) begin
                    div    <= '0;
                    mclk_r <= ~mclk_r;
                end else begin
                    div <= div + DW'(1);
                end
                if (sample_ev) begin
                    if (win_end) begin
                        bit_cnt <= '0;
                        acc     <= '0;
                        if (state == S_WARMUP) wu_cnt <= wu_cnt + WUW'(1);
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                        acc     <= acc + AW'(d_s);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mic_pdm_capture.sv
// Bench for mic_pdm_capture with a reduced geometry (mclk period 8, 16-bit
// windows) so warmup and several windows fit in a few thousand cycles.
module tb_mic_pdm_capture;
    localparam int CLK_DIV = 4;
    localparam int DECIM   = 16;
    localparam int W       = 5;
    localparam int WARMUP  = 2;
    localparam int MCLK_P  = 2 * CLK_DIV;
    localparam int WIN     = MCLK_P * DECIM;
    localparam int FIRST   = (WARMUP + 1) * WIN;

    logic clk_in;
    logic rst;
    int   cyc;
    int   errors;
    int   checks;
    logic [W-1:0] exp_q[$];
    int   exp_cyc_q[$];
    logic prev_done;
    logic mclk_prev;

    mic_pdm_capture_if #(.W(W)) bus ();

    mic_pdm_capture #(
        .CLK_DIV(CLK_DIV),
        .DECIM  (DECIM),
        .W      (W),
        .WARMUP (WARMUP)
    ) dut (
        .clk_in(clk_in),
        .rst   (rst),
        .bus   (bus.master)
    );

    // clock / reset-independent cycle counter
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_done(input int at_cyc, input logic [W-1:0] pcm);
        exp_q.push_back(pcm);
        exp_cyc_q.push_back(at_cyc);
    endtask

    task automatic run_to(input int target, input bit toggle);
        while (cyc < target) begin
            @(negedge clk_in);
            if (toggle && bus.mclk && !mclk_prev) bus.mic_data = ~bus.mic_data;
            mclk_prev = bus.mclk;
        end
    endtask

    task automatic measure_mclk(output int hi, output int lo);
        int n;
        hi = 0;
        lo = 0;
        n  = 0;
        while (bus.mclk !== 1'b0 && n < 20) begin @(negedge clk_in); n++; end
        n = 0;
        while (bus.mclk !== 1'b1 && n < 20) begin @(negedge clk_in); n++; end
        while (bus.mclk === 1'b1 && hi < 20) begin @(negedge clk_in); hi++; end
        while (bus.mclk === 1'b0 && lo < 20) begin @(negedge clk_in); lo++; end
    endtask

    // scoreboard monitor
    always @(negedge clk_in) begin
        logic [W-1:0] e;
        int t;
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (bus.done) begin
                check("done_back_to_back", int'(prev_done), 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done at cycle %0d pcm_out=%0d, none expected",
                             cyc, bus.pcm_out);
                end else begin
                    e = exp_q.pop_front();
                    t = exp_cyc_q.pop_front();
                    check("pcm_out_at_done", int'(bus.pcm_out), int'(e));
                    check("done_cycle", cyc, t);
                end
            end
            prev_done = bus.done;
        end
    end

    initial begin
        int t0;
        int hi;
        int lo;
        errors       = 0;
        checks       = 0;
        prev_done    = 1'b0;
        mclk_prev    = 1'b0;
        rst          = 1'b1;
        bus.enable   = 1'b0;
        bus.mic_data = 1'b0;

        repeat (3) @(negedge clk_in);
        check("reset_pcm", int'(bus.pcm_out), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_active", int'(bus.active), 0);
        check("reset_mclk", int'(bus.mclk), 0);
        check("lrsel", int'(bus.mic_lrsel), 0);
        rst = 1'b0;
        repeat (6) @(negedge clk_in);
        check("idle_mclk", int'(bus.mclk), 0);
        check("idle_state", int'(bus.state), 0);

        // all-ones stream; enable drops exactly on the third RUN window end
        bus.mic_data = 1'b1;
        repeat (4) @(negedge clk_in);
        bus.enable = 1'b1;
        t0 = cyc + 1;
        expect_done(t0 + FIRST, 5'd16);
        expect_done(t0 + FIRST + WIN, 5'd16);
        expect_done(t0 + FIRST + 2 * WIN, 5'd16);
        run_to(t0 + 1, 0);
        check("warmup_state", int'(bus.state), 1);
        run_to(t0 + CLK_DIV - 1, 0);
        check("mclk_before_first_rise", int'(bus.mclk), 0);
        run_to(t0 + CLK_DIV, 0);
        check("mclk_first_rise", int'(bus.mclk), 1);
        run_to(t0 + WARMUP * WIN - 1, 0);
        check("active_in_warmup", int'(bus.active), 0);
        run_to(t0 + WARMUP * WIN, 0);
        check("active_in_run", int'(bus.active), 1);
        run_to(t0 + FIRST + 2 * WIN - 1, 0);
        bus.enable = 1'b0;
        run_to(t0 + FIRST + 2 * WIN, 0);
        check("exact_end_active", int'(bus.active), 0);
        check("exact_end_mclk", int'(bus.mclk), 0);
        check("exact_end_state", int'(bus.state), 0);
        run_to(t0 + FIRST + 2 * WIN + 5, 0);
        check("t1_queue_drained", exp_q.size(), 0);

        // re-enable repeats warmup; enable drops mid-window
        repeat (10) @(negedge clk_in);
        bus.enable = 1'b1;
        t0 = cyc + 1;
        expect_done(t0 + FIRST, 5'd16);
        expect_done(t0 + FIRST + WIN, 5'd16);
        run_to(t0 + FIRST + WIN + WIN / 2 + 1, 0);
        bus.enable = 1'b0;
        run_to(t0 + FIRST + WIN + WIN / 2 + 2, 0);
        check("drop_mclk", int'(bus.mclk), 0);
        check("drop_active", int'(bus.active), 0);
        run_to(t0 + FIRST + 3 * WIN, 0);
        check("drop_pcm_hold", int'(bus.pcm_out), 16);
        check("t2_queue_drained", exp_q.size(), 0);

        // all-zeros stream and mclk shape
        bus.mic_data = 1'b0;
        repeat (4) @(negedge clk_in);
        bus.enable = 1'b1;
        t0 = cyc + 1;
        expect_done(t0 + FIRST, 5'd0);
        expect_done(t0 + FIRST + WIN, 5'd0);
        run_to(t0 + 20, 0);
        measure_mclk(hi, lo);
        check("mclk_high_len", hi, CLK_DIV);
        check("mclk_low_len", lo, CLK_DIV);
        check("mclk_period", hi + lo, MCLK_P);
        run_to(t0 + FIRST + WIN + 3, 0);
        bus.enable = 1'b0;
        check("t3_pcm", int'(bus.pcm_out), 0);
        check("t3_queue_drained", exp_q.size(), 0);

        // alternating bits, one per mclk period
        repeat (4) @(negedge clk_in);
        bus.mic_data = 1'b0;
        mclk_prev    = bus.mclk;
        bus.enable   = 1'b1;
        t0 = cyc + 1;
        expect_done(t0 + FIRST, 5'd8);
        expect_done(t0 + FIRST + WIN, 5'd8);
        run_to(t0 + FIRST + WIN + 60, 1);
        check("t4_queue_drained", exp_q.size(), 0);

        // asynchronous reset mid-window, off the clock edge
        #2 rst = 1'b1;
        #1;
        check("async_rst_pcm", int'(bus.pcm_out), 0);
        check("async_rst_done", int'(bus.done), 0);
        check("async_rst_active", int'(bus.active), 0);
        check("async_rst_mclk", int'(bus.mclk), 0);
        repeat (3) @(negedge clk_in);
        bus.mic_data = 1'b1;
        rst = 1'b0;
        t0 = cyc + 1;
        expect_done(t0 + FIRST, 5'd16);
        run_to(t0 + FIRST + 4, 0);
        bus.enable = 1'b0;
        check("t5_queue_drained", exp_q.size(), 0);
        repeat (4) @(negedge clk_in);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end
endmodule
